// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a 4-word line refill from the memory controller.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STAT_EN.
module icache_direct #(
    parameter int  INDEX_BITS = 6,
    localparam int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_cache,
    input  logic        pc_valid,
    output logic [31:0] ins_ori,
    output logic        ins_ori_flag,
    output logic        cache_busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        mem_done,
    input  logic        jp_wrong
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIT_RSP  = 2'd1,
        REFILL   = 2'd2,
        MISS_RSP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:2]        pc_q, pc_d;
    logic [1:0]         word_cnt_q, word_cnt_d;
    logic               drop_q, drop_d;
    logic [31:0]        ins_q, ins_d;
    logic               busy_q, busy_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic [LINES-1:0]   valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [31:0]        data_q [LINES][4];

    logic [INDEX_BITS-1:0] req_idx, cur_idx;
    logic [TAG_BITS-1:0]   req_tag, cur_tag;
    logic [1:0]            cur_off;
    logic                  req_hit;
    logic [31:0]           rsp_word;
    logic                  accept, fill_we, install, rsp_flag;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^pc_cache[1:0];

    assign req_idx  = pc_cache[3+INDEX_BITS:4];
    assign req_tag  = pc_cache[31:4+INDEX_BITS];
    assign cur_idx  = pc_q[3+INDEX_BITS:4];
    assign cur_tag  = pc_q[31:4+INDEX_BITS];
    assign cur_off  = pc_q[3:2];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rsp_word = data_q[cur_idx][cur_off];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        word_cnt_d = word_cnt_q;
        drop_d     = drop_q;
        ins_d      = ins_q;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        accept     = 1'b0;
        fill_we    = 1'b0;
        install    = 1'b0;
        rsp_flag   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pc_valid && !jp_wrong) begin
                    accept = 1'b1;
                    pc_d   = pc_cache[31:2];
                    busy_d = 1'b1;
                    if (req_hit) begin
                        state_d = HIT_RSP;
                    end else begin
                        state_d    = REFILL;
                        word_cnt_d = 2'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pc_cache[31:4], 4'b0000};
                    end
                end
            end
            HIT_RSP, MISS_RSP: begin
                rsp_flag = !jp_wrong && !drop_q;
                if (rsp_flag) begin
                    ins_d = rsp_word;
                end
                busy_d  = 1'b0;
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            REFILL: begin
                // A flush cannot abort the memory handshake; it only marks the response dead.
                if (jp_wrong) begin
                    drop_d = 1'b1;
                end
                if (mem_done) begin
                    fill_we    = 1'b1;
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        mem_req_d = 1'b0;
                        install   = 1'b1;
                        state_d   = MISS_RSP;
                    end else begin
                        mem_addr_d = {pc_q[31:4], word_cnt_q + 2'd1, 2'b00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            word_cnt_q <= 2'd0;
            drop_q     <= 1'b0;
            ins_q      <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            word_cnt_q <= word_cnt_d;
            drop_q     <= drop_d;
            ins_q      <= ins_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if (install) begin
                valid_q[cur_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (fill_we) begin
                data_q[cur_idx][word_cnt_q] <= mem_ins;
            end
            if (install) begin
                tag_q[cur_idx] <= cur_tag;
            end
        end
    end

    assign ins_ori_flag = rsp_flag && rdy;
    assign ins_ori      = ins_ori_flag ? rsp_word : ins_q;
    assign cache_busy   = busy_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy && accept) begin
            if (req_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
